// File: rtl/alu_cmd_seq_pkg.sv
// Shared constants for the command-sequenced ALU: data width, opcodes and FSM states.
package alu_cmd_seq_pkg;

    localparam int unsigned DATA_W = 8;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    typedef enum logic [1:0] {
        StIdle   = 2'b00,
        StExec   = 2'b01,
        StResult = 2'b10
    } state_t;

endpackage

// File: rtl/alu_cmd_seq_alu_8bit.sv
// Combinational 8-bit ALU: add/sub produce a 9-bit result whose top bit is carry/borrow.
module alu_8bit
    import alu_cmd_seq_pkg::*;
(
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] y,
    output logic              carry,
    output logic              zero
);

    logic [DATA_W:0] wide;

    always_comb begin
        wide = '0;
        unique case (op)
            OP_ADD: wide = {1'b0, a} + {1'b0, b};
            OP_SUB: wide = {1'b0, a} - {1'b0, b};
            OP_AND: wide = {1'b0, a & b};
            OP_OR:  wide = {1'b0, a | b};
        endcase
    end

    assign y     = wide[DATA_W-1:0];
    assign carry = wide[DATA_W];
    assign zero  = (y == '0);

endmodule

// File: rtl/alu_cmd_seq.sv
// Command sequencer: accepts one ALU command, executes it, holds the result until
// it is consumed. All outputs come straight from registers.
module alu_cmd_seq
    import alu_cmd_seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    input  logic              cmd_use_acc,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_y,
    output logic              res_carry,
    output logic              res_zero,
    output logic [DATA_W-1:0] acc,
    output logic [DATA_W-1:0] res_count
);

    state_t            state;
    logic [1:0]        op_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;

    logic [DATA_W-1:0] alu_y;
    logic              alu_carry;
    logic              alu_zero;

    alu_8bit u_alu (
        .op    (op_q),
        .a     (a_q),
        .b     (b_q),
        .y     (alu_y),
        .carry (alu_carry),
        .zero  (alu_zero)
    );

    // cmd_ready is kept high exactly while in StIdle, so cmd_valid alone qualifies acceptance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= StIdle;
            cmd_ready <= 1'b1;
            res_valid <= 1'b0;
            op_q      <= OP_ADD;
            a_q       <= '0;
            b_q       <= '0;
            res_y     <= '0;
            res_carry <= 1'b0;
            res_zero  <= 1'b0;
            acc       <= '0;
            res_count <= '0;
        end else begin
            case (state)
                StIdle: begin
                    if (cmd_valid) begin
                        op_q      <= cmd_op;
                        a_q       <= cmd_use_acc ? acc : cmd_a;
                        b_q       <= cmd_b;
                        cmd_ready <= 1'b0;
                        state     <= StExec;
                    end
                end
                StExec: begin
                    res_y     <= alu_y;
                    res_carry <= alu_carry;
                    res_zero  <= alu_zero;
                    acc       <= alu_y;
                    res_valid <= 1'b1;
                    state     <= StResult;
                end
                StResult: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        res_count <= res_count + 8'd1;
                        state     <= StIdle;
                    end
                end
                default: begin
                    state     <= StIdle;
                    cmd_ready <= 1'b1;
                    res_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cmd_seq.sv
// Self-checking bench for alu_cmd_seq: directed scenarios plus random commands
// checked against an arithmetic reference model.
module tb_alu_cmd_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'b00;
    logic [7:0] cmd_a = 8'h00;
    logic [7:0] cmd_b = 8'h00;
    logic       cmd_use_acc = 1'b0;
    logic       res_valid;
    logic       res_ready = 1'b0;
    logic [7:0] res_y;
    logic       res_carry;
    logic       res_zero;
    logic [7:0] acc;
    logic [7:0] res_count;

    int checks = 0;
    int errors = 0;
    int acc_m = 0;
    int count_m = 0;

    alu_cmd_seq dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_a       (cmd_a),
        .cmd_b       (cmd_b),
        .cmd_use_acc (cmd_use_acc),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_y       (res_y),
        .res_carry   (res_carry),
        .res_zero    (res_zero),
        .acc         (acc),
        .res_count   (res_count)
    );

    always #5 clk = ~clk;

    // Reference: plain integer arithmetic; result packed as carry*256 + y.
    function automatic int model(input int op, input int a, input int b);
        int y, c;
        case (op)
            0: begin y = (a + b) % 256; c = (a + b > 255) ? 1 : 0; end
            1: begin y = (a - b + 256) % 256; c = (a < b) ? 1 : 0; end
            2: begin y = a & b; c = 0; end
            default: begin y = a | b; c = 0; end
        endcase
        return c * 256 + y;
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Issue one command from StIdle; optionally hold res_ready low for 'hold' cycles,
    // and complete the handshake if 'complete' is set.
    task automatic run_cmd(input int op, input int a, input int b, input bit use_acc,
                           input int hold, input bit complete);
        int a_eff, r, exp_y, exp_c, exp_z, edges;
        a_eff = use_acc ? acc_m : a;
        r     = model(op, a_eff, b);
        exp_y = r % 256;
        exp_c = r / 256;
        exp_z = (exp_y == 0) ? 1 : 0;

        @(negedge clk);
        chk("cmd_ready_idle", int'(cmd_ready), 1);
        cmd_valid   = 1'b1;
        cmd_op      = op[1:0];
        cmd_a       = a[7:0];
        cmd_b       = b[7:0];
        cmd_use_acc = use_acc;
        res_ready   = 1'b1;
        @(posedge clk);
        edges = 1;
        @(negedge clk);
        // Garbage on the command port while busy must be ignored.
        cmd_op      = 2'($urandom);
        cmd_a       = 8'($urandom);
        cmd_b       = 8'($urandom);
        cmd_use_acc = 1'($urandom);
        chk("res_valid_exec", int'(res_valid), 0);
        while (!res_valid && edges < 10) begin
            @(posedge clk);
            @(negedge clk);
            edges++;
        end
        chk("latency_edges", edges, 2);
        chk("res_y", int'(res_y), exp_y);
        chk("res_carry", int'(res_carry), exp_c);
        chk("res_zero", int'(res_zero), exp_z);
        acc_m = exp_y;
        chk("acc", int'(acc), acc_m);
        for (int i = 0; i < hold; i++) begin
            res_ready = 1'b0;
            @(posedge clk);
            @(negedge clk);
            chk("hold_valid", int'(res_valid), 1);
            chk("hold_y", int'(res_y), exp_y);
            chk("hold_carry", int'(res_carry), exp_c);
            chk("hold_cmd_ready", int'(cmd_ready), 0);
            chk("hold_count", int'(res_count), count_m);
        end
        cmd_valid = 1'b0;
        res_ready = 1'b0;
        if (complete) begin
            res_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            res_ready = 1'b0;
            count_m = (count_m + 1) % 256;
            chk("post_valid", int'(res_valid), 0);
            chk("post_cmd_ready", int'(cmd_ready), 1);
            chk("post_count", int'(res_count), count_m);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        acc_m = 0;
        count_m = 0;
        chk("rst_valid", int'(res_valid), 0);
        chk("rst_cmd_ready", int'(cmd_ready), 1);
        chk("rst_acc", int'(acc), 0);
        chk("rst_count", int'(res_count), 0);
        chk("rst_y", int'(res_y), 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
    endtask

    task automatic test_reset_mid_result();
        run_cmd(0, 1, 1, 1'b0, 0, 1'b0);
        chk("pre_rst_valid", int'(res_valid), 1);
        do_reset();
    endtask

    task automatic test_arith();
        run_cmd(0, 200, 100, 1'b0, 0, 1'b1);
        run_cmd(1, 5, 5, 1'b0, 0, 1'b1);
        run_cmd(1, 3, 5, 1'b0, 0, 1'b1);
        run_cmd(0, 10, 20, 1'b0, 0, 1'b1);
        run_cmd(0, 99, 5, 1'b1, 0, 1'b1);
        chk("use_acc_y", int'(res_y), 35);
        run_cmd(2, 8'hF0, 8'h3C, 1'b0, 0, 1'b1);
        chk("and_y", int'(res_y), 8'h30);
    endtask

    task automatic test_backpressure();
        run_cmd(3, 8'h55, 8'h0A, 1'b0, 5, 1'b1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++)
            run_cmd(int'($urandom_range(3)), int'($urandom_range(255)),
                    int'($urandom_range(255)), 1'($urandom), int'($urandom_range(3)), 1'b1);
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 256; i++) begin
            if (i == 255) chk("count_255", int'(res_count), 255);
            run_cmd(3, 0, 1, 1'b0, 0, 1'b1);
        end
        chk("count_wrap", int'(res_count), 0);
    endtask

    initial begin
        #12 rst = 1'b0;
        test_reset();
        test_reset_mid_result();
        test_arith();
        test_backpressure();
        test_random();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_cmd_seq.md
ALU_CMD_SEQ -- requirements
Module: alu_cmd_seq

Interface
- No parameters; all datapaths are fixed at 8 bits.
- REQ-001: The block SHALL have one clock and asynchronous, active-high reset.
  - clk  input  1  rising-edge clock.
  - rst  input  1  asynchronous reset, active-high.
- REQ-002: The command port SHALL consist of:
  - cmd_valid    input   1  command present.
  - cmd_ready    output  1  block can accept a command.
  - cmd_op       input   2  00 add, 01 sub, 10 and, 11 or.
  - cmd_a        input   8  operand A.
  - cmd_b        input   8  operand B.
  - cmd_use_acc  input   1  replace operand A with the accumulator.
- REQ-003: The result port SHALL consist of:
  - res_valid  output  1  result present.
  - res_ready  input   1  consumer accepts the result.
  - res_y      output  8  result.
  - res_carry  output  1  carry/borrow.
  - res_zero   output  1  res_y == 0.
- REQ-004: The block SHALL output acc (8 bits), the last accepted result, and res_count (8 bits), the number of results delivered, modulo 256.

Function
- REQ-005: The FSM SHALL have three states: IDLE, EXEC and RESULT.
- REQ-006: In IDLE, cmd_ready SHALL be 1; in all other states it SHALL be 0.
- REQ-007: When cmd_valid && cmd_ready at a clock edge, the block SHALL capture op, effective A (acc if cmd_use_acc, else cmd_a) and B, then go to EXEC.
- REQ-008: In EXEC, the block SHALL drive the captured operands into the ALU and register y/carry/zero into res_* and y into acc, then go to RESULT.
- REQ-009: In RESULT, res_valid SHALL be 1 and res_* SHALL remain stable until res_valid && res_ready.
- REQ-010: On the res_valid && res_ready edge, the block SHALL go to IDLE and increment res_count, wrapping 255 -> 0.
- REQ-011: Latency SHALL be fixed: res_valid rises 2 edges after command acceptance; peak throughput is 1 command per 3 cycles.
- REQ-012: Arithmetic SHALL be unsigned.
  - Add: 9-bit sum, carry = bit 8.
  - Sub: 9-bit A-B, carry = bit 8 (1 = borrow).
  - And/or: carry = 0.
  - zero is computed on the 8-bit y for every op.
- REQ-013: In IDLE and EXEC, res_valid SHALL be 0; res_ready in those states SHALL have no effect.
- REQ-014: Because cmd_ready is 0 outside IDLE, a command SHALL never overlap a pending result; cmd_* changes while cmd_ready = 0 SHALL be ignored.
- REQ-015: Outputs SHALL be registered only; no combinational path from cmd_* or res_ready to any output.

Reset
- REQ-016: Asserting rst SHALL immediately force state IDLE, res_valid 0, cmd_ready 1 and res_y/res_carry/res_zero/acc/res_count 0, including mid-EXEC or mid-RESULT.
- REQ-017: A command or result in flight during reset SHALL be discarded; after rst deasserts, the first edge SHALL accept a valid command.

Structure
- REQ-018: A shared package SHALL hold:
  - opcode constants (OP_ADD = 2'b00, OP_SUB = 2'b01, OP_AND = 2'b10, OP_OR = 2'b11);
  - the FSM state encoding;
  - the data width constant 8.
- REQ-019: The block SHALL instantiate exactly one combinational sub-module, alu_8bit, for the arithmetic.
- REQ-020: The sequencer SHALL contain only the FSM, operand/result registers, the accumulator and the counter.

Verification
- REQ-021: The bench SHALL cover these directed scenarios:
  - Reset mid-RESULT (after ADD 1+1) -> res_valid 0, acc 0, res_count 0, cmd_ready 1 on the same cycle.
  - ADD a=200, b=100 -> res_y 0x2C, res_carry 1, res_zero 0, res_valid exactly 2 edges after accept.
  - SUB 5-5 -> res_y 0x00, res_zero 1, res_carry 0; SUB 3-5 -> res_y 0xFE, res_carry 1.
  - ADD 10+20, then ADD with cmd_use_acc=1, cmd_a=99, b=5 -> res_y 35 (cmd_a ignored); AND 0xF0&0x3C -> 0x30, carry 0.
  - res_ready held 0 for 5 cycles in RESULT -> res_* stable, cmd_ready 0, res_count unchanged until handshake.
  - 256 back-to-back OR 0|1 transactions -> res_count wraps from 255 to 0.
